// File: rtl/fp_convert_sched.sv
// fp_convert_sched: time-shares one float-to-decimal converter among NREQ
// requesters. Round-robin grant, one operand in flight, result presented on a
// registered valid/ready port tagged with the requester id and an exponent
// range flag.
module fp_convert_sched #(
  parameter int NREQ     = 4,
  parameter int CONV_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [32*NREQ-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [31:0]             conv_a,
  input  logic [3:0]              conv_phan_nguyen,
  input  logic [9:0]              conv_phan_thapphan,
  input  logic [5:0]              conv_phan_mu,
  input  logic                    conv_sign_phanmu,
  input  logic                    conv_sign_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic [3:0]              out_nguyen,
  output logic [9:0]              out_thapphan,
  output logic [5:0]              out_mu,
  output logic                    out_sign_mu,
  output logic                    out_sign,
  output logic                    out_range_err,
  output logic                    busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;

  typedef struct packed {
    logic [3:0] nguyen;
    logic [9:0] thapphan;
    logic [5:0] mu;
    logic       sign_mu;
    logic       sign;
  } conv_res_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt;
  conv_res_t      res;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [31:0]    req_word [NREQ];

  // Split the flat operand bus into one word per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_data[32*i +: 32];
  end

  // Exponent is representable only when |E-127| fits the 6-bit magnitude;
  // zero/denormal and inf/NaN encodings are always flagged.
  function automatic logic range_err(input logic [7:0] e);
    int d;
    d = int'(e) - 127;
    return (e == 8'd0) || (e == 8'hFF) || (d > 63) || (d < -63);
  endfunction

  // Round-robin search: walk offsets from high to low so the lowest offset
  // from rr_ptr that is valid wins.
  always_comb begin
    int s;
    logic [IDW-1:0] j;
    s       = 0;
    j       = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      j = IDW'(s);
      if (req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = j;
      end
    end
  end

  // Accept strobe only while idle; suppressed during reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Scheduler FSM: accept -> wait converter latency -> present result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      conv_a        <= '0;
      out_id        <= '0;
      res           <= '0;
      out_range_err <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            conv_a        <= req_word[gnt_idx];
            out_id        <= gnt_idx;
            cnt           <= CW'(CONV_LAT - 1);
            out_range_err <= range_err(req_word[gnt_idx][30:23]);
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            res       <= '{nguyen:   conv_phan_nguyen,
                           thapphan: conv_phan_thapphan,
                           mu:       conv_phan_mu,
                           sign_mu:  conv_sign_phanmu,
                           sign:     conv_sign_out};
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= (out_id == IDW'(NREQ - 1)) ? '0 : out_id + IDW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_nguyen   = res.nguyen;
  assign out_thapphan = res.thapphan;
  assign out_mu       = res.mu;
  assign out_sign_mu  = res.sign_mu;
  assign out_sign     = res.sign;
  assign busy         = (state != IDLE);

endmodule
